// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited request issue, in-order response buffer,
// redirect handling with stale-response discard counting.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned SW = CW + 2;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_instr_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [31:0]   r_buf [DEPTH];

  logic          w_grant;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;
  logic          w_answered;
  logic [SW-1:0] w_credit_used;
  logic [CW-1:0] w_discard_redir;
  logic [31:0]   w_redirect_pc;

  always_comb begin
    // Responses already marked for discard still occupy a credit until they return.
    w_credit_used   = SW'(r_outstanding) + SW'(r_discard) + SW'(r_count);
    imem_req        = rst_n && !redirect_valid && (w_credit_used < SW'(DEPTH));
    imem_addr       = r_fetch_pc;
    instr_valid     = rst_n && (r_count != '0);
    instr           = r_buf[r_head];
    instr_pc        = r_instr_pc;
    w_grant         = imem_req && imem_gnt;
    w_drop          = imem_rvalid && (r_discard != '0);
    w_answered      = imem_rvalid && (r_discard == '0);
    w_push          = w_answered && !redirect_valid;
    w_pop           = instr_valid && instr_ready;
    w_redirect_pc   = redirect_pc & ~32'h0000_0003;
    w_discard_redir = CW'(SW'(r_outstanding) + SW'(r_discard) - SW'(imem_rvalid));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_instr_pc    <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_head        <= '0;
      r_tail        <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc    <= w_redirect_pc;
      r_instr_pc    <= w_redirect_pc;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= w_discard_redir;
      r_head        <= '0;
      r_tail        <= '0;
    end else begin
      if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_pop) begin
        r_instr_pc <= r_instr_pc + 32'd4;
        r_head     <= r_head + PW'(1);
      end
      if (w_push) r_tail <= r_tail + PW'(1);
      r_count       <= r_count + CW'(w_push) - CW'(w_pop);
      r_outstanding <= r_outstanding + CW'(w_grant) - CW'(w_answered);
      r_discard     <= r_discard - CW'(w_drop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_buf[r_tail] <= imem_rdata;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && (r_count == CW'(DEPTH))))
    else $error("fetch_unit: push into full instruction buffer");

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a DEPTH=2 instance carries most checks, a DEPTH=4
// instance on the same inputs shows full single-cycle throughput.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, gnt, redir, ready, mem_en;
  logic [31:0] redir_pc;
  logic        d2_req, d2_rvalid, d2_valid;
  logic [31:0] d2_addr, d2_rdata, d2_instr, d2_pc;
  logic        d4_req, d4_rvalid, d4_valid;
  logic [31:0] d4_addr, d4_rdata, d4_instr, d4_pc;

  logic [31:0] q2[$];
  logic [31:0] q4[$];
  logic        g2, g4, rst_s;
  logic [31:0] a2, a4;
  int          checks = 0;
  int          failures = 0;
  int          gcnt;

  fetch_unit #(.DEPTH(2)) u_d2 (
    .clk(clk), .rst_n(rst_n),
    .imem_req(d2_req), .imem_addr(d2_addr), .imem_gnt(gnt),
    .imem_rvalid(d2_rvalid), .imem_rdata(d2_rdata),
    .redirect_valid(redir), .redirect_pc(redir_pc),
    .instr_valid(d2_valid), .instr_ready(ready),
    .instr(d2_instr), .instr_pc(d2_pc)
  );

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) u_d4 (
    .clk(clk), .rst_n(rst_n),
    .imem_req(d4_req), .imem_addr(d4_addr), .imem_gnt(gnt),
    .imem_rvalid(d4_rvalid), .imem_rdata(d4_rdata),
    .redirect_valid(redir), .redirect_pc(redir_pc),
    .instr_valid(d4_valid), .instr_ready(ready),
    .instr(d4_instr), .instr_pc(d4_pc)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hE000_0013 ^ (a << 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // In-order memory with one cycle of latency; mem_en=0 holds responses back.
  task automatic tick();
    @(negedge clk);
    g2 = d2_req && gnt; a2 = d2_addr;
    g4 = d4_req && gnt; a4 = d4_addr;
    rst_s = rst_n;
    @(posedge clk);
    #1;
    if (!rst_s) begin
      q2.delete(); q4.delete();
      d2_rvalid = 1'b0; d4_rvalid = 1'b0;
    end else begin
      if (g2) q2.push_back(a2);
      if (g4) q4.push_back(a4);
      if (mem_en && q2.size() > 0) begin
        d2_rvalid = 1'b1; d2_rdata = word(q2.pop_front());
      end else d2_rvalid = 1'b0;
      if (mem_en && q4.size() > 0) begin
        d4_rvalid = 1'b1; d4_rdata = word(q4.pop_front());
      end else d4_rvalid = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; gnt = 1'b1; redir = 1'b0; redir_pc = '0; ready = 1'b1; mem_en = 1'b1;
    d2_rvalid = 1'b0; d2_rdata = '0; d4_rvalid = 1'b0; d4_rdata = '0;
    tick(); tick();
    #1;
    chk("rst_req_d2", d2_req, 0);
    chk("rst_valid_d2", d2_valid, 0);
    chk("rst_req_d4", d4_req, 0);
    rst_n = 1'b1;

    // Streaming after reset release.
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("stream_addr_d4", d4_addr, 32'(4 * k));
      if (k < 2) chk("stream_nvalid_d4", d4_valid, 0);
      else begin
        chk("stream_valid_d4", d4_valid, 1);
        chk("stream_pc_d4", d4_pc, 32'(4 * (k - 2)));
        chk("stream_instr_d4", d4_instr, word(32'(4 * (k - 2))));
      end
      if (k == 0) begin
        chk("first_req_d2", d2_req, 1);
        chk("first_addr_d2", d2_addr, 32'h0);
      end
      if (k == 1) chk("lat_nvalid_d2", d2_valid, 0);
      if (k == 2) begin
        chk("lat_valid_d2", d2_valid, 1);
        chk("lat_pc_d2", d2_pc, 32'h0);
        chk("lat_instr_d2", d2_instr, word(32'h0));
      end
      tick();
    end

    // Backpressure on DEPTH=2.
    rst_n = 1'b0; ready = 1'b0;
    #1;
    chk("mid_rst_req", d2_req, 0);
    chk("mid_rst_valid", d2_valid, 0);
    tick();
    rst_n = 1'b1;
    gcnt = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (d2_req && gnt) gcnt++;
      tick();
    end
    #1;
    chk("bp_grants", gcnt, 2);
    chk("bp_req_off", d2_req, 0);
    chk("bp_valid", d2_valid, 1);
    chk("bp_pc0", d2_pc, 32'h0);
    chk("bp_instr0", d2_instr, word(32'h0));
    ready = 1'b1;
    tick();
    #1;
    chk("bp_valid1", d2_valid, 1);
    chk("bp_pc1", d2_pc, 32'h4);
    chk("bp_instr1", d2_instr, word(32'h4));
    tick();
    ready = 1'b0;
    tick(); tick(); tick(); tick();
    #1;
    chk("full_valid", d2_valid, 1);
    chk("full_pc", d2_pc, 32'h8);
    chk("full_instr", d2_instr, word(32'h8));
    chk("full_req_off", d2_req, 0);

    // One-cycle reset with a full buffer.
    rst_n = 1'b0;
    #1;
    chk("full_rst_req", d2_req, 0);
    chk("full_rst_valid", d2_valid, 0);
    tick();
    rst_n = 1'b1; ready = 1'b1; mem_en = 1'b0;
    #1;
    chk("after_rst_valid", d2_valid, 0);
    chk("after_rst_addr", d2_addr, 32'h0);
    chk("after_rst_req", d2_req, 1);
    tick();
    #1;
    chk("held_req", d2_req, 1);
    chk("held_addr", d2_addr, 32'h4);
    tick();

    // Redirect with two requests outstanding; low address bits ignored.
    #1;
    chk("two_out_req", d2_req, 0);
    redir = 1'b1; redir_pc = 32'h0000_0103; mem_en = 1'b1;
    tick();
    redir = 1'b0;
    #1;
    chk("redir_addr", d2_addr, 32'h100);
    chk("redir_nvalid", d2_valid, 0);
    chk("redir_credit", d2_req, 0);
    tick();
    #1;
    chk("drop1_nvalid", d2_valid, 0);
    chk("drop1_req", d2_req, 1);
    chk("drop1_addr", d2_addr, 32'h100);
    tick();
    #1;
    chk("drop2_nvalid", d2_valid, 0);
    tick();
    #1;
    chk("redir_valid", d2_valid, 1);
    chk("redir_pc", d2_pc, 32'h100);
    chk("redir_instr", d2_instr, word(32'h100));

    // Redirect coinciding with a response and a pop.
    redir = 1'b1; redir_pc = 32'h0000_0200;
    tick();
    redir = 1'b0;
    #1;
    chk("rv_redir_nvalid", d2_valid, 0);
    chk("rv_redir_addr", d2_addr, 32'h200);
    chk("rv_redir_req", d2_req, 1);
    tick();
    #1;
    chk("rv_wait_nvalid", d2_valid, 0);
    tick();
    #1;
    chk("rv_deliver_valid", d2_valid, 1);
    chk("rv_deliver_pc", d2_pc, 32'h200);
    chk("rv_deliver_instr", d2_instr, word(32'h200));
    tick();

    // Grant withheld for three cycles.
    gnt = 1'b0;
    #1;
    chk("gw_pc", d2_pc, 32'h204);
    chk("gw_instr", d2_instr, word(32'h204));
    chk("gw_req0", d2_req, 1);
    chk("gw_addr0", d2_addr, 32'h208);
    tick();
    #1;
    chk("gw_req1", d2_req, 1);
    chk("gw_addr1", d2_addr, 32'h208);
    tick();
    #1;
    chk("gw_req2", d2_req, 1);
    chk("gw_addr2", d2_addr, 32'h208);
    tick();
    gnt = 1'b1; mem_en = 1'b0;
    #1;
    chk("gw_req3", d2_req, 1);
    chk("gw_addr3", d2_addr, 32'h208);
    tick();
    #1;
    chk("gw_advance", d2_addr, 32'h20C);
    tick();

    // Back-to-back redirects, second one alongside a stale response.
    #1;
    chk("bb_full_req", d2_req, 0);
    redir = 1'b1; redir_pc = 32'h0000_0300;
    tick();
    redir = 1'b0; mem_en = 1'b1;
    #1;
    chk("bb_addr300", d2_addr, 32'h300);
    chk("bb_credit", d2_req, 0);
    tick();
    #1;
    chk("bb_stale_nvalid", d2_valid, 0);
    redir = 1'b1; redir_pc = 32'h0000_0400;
    tick();
    redir = 1'b0;
    #1;
    chk("bb_addr400", d2_addr, 32'h400);
    chk("bb_req400", d2_req, 1);
    chk("bb_nvalid", d2_valid, 0);
    tick();
    #1;
    chk("bb_nvalid2", d2_valid, 0);
    chk("bb_addr404", d2_addr, 32'h404);
    tick();
    #1;
    chk("bb_valid", d2_valid, 1);
    chk("bb_pc", d2_pc, 32'h400);
    chk("bb_instr", d2_instr, word(32'h400));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
